// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that shares one UART byte stream among NUM_REQ 16-bit word sources, low byte first.
// Optional: define UART_TX_SCHEDULER_HDR_EN to prefix each word with header byte {4'hA, 1'b0, grant_id}.
module uart_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 16,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic                  byte_valid,
  output logic [7:0]            byte_data,
  input  logic                  byte_ready,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id
);
  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef UART_TX_SCHEDULER_HDR_EN
    S_HDR,
`endif
    S_LO,
    S_HI,
    S_ACK,
    S_GAP
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [15:0]    r_word;
  logic [IDW-1:0] r_grant_id;
  logic [IDW-1:0] r_rr_ptr;
  logic [CW-1:0]  r_gap_cnt;
  logic           w_found;
  logic [IDW-1:0] w_gidx;
  logic           w_xfer;

  // Search starts just past the last served requester, so it drops to lowest priority.
  always_comb begin : grant_search
    int idx;
    w_found = 1'b0;
    w_gidx  = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_gidx  = IDW'(idx);
      end
    end
  end

  assign w_xfer   = byte_valid & byte_ready;
  assign grant_id = r_grant_id;

  always_comb begin
    w_next     = r_state;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    req_ack    = '0;
    busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_found) begin
`ifdef UART_TX_SCHEDULER_HDR_EN
          w_next = S_HDR;
`else
          w_next = S_LO;
`endif
        end
      end
`ifdef UART_TX_SCHEDULER_HDR_EN
      S_HDR: begin
        byte_valid = 1'b1;
        byte_data  = {4'hA, 1'b0, 3'(r_grant_id)};
        if (w_xfer) w_next = S_LO;
      end
`endif
      S_LO: begin
        byte_valid = 1'b1;
        byte_data  = r_word[7:0];
        if (w_xfer) w_next = S_HI;
      end
      S_HI: begin
        byte_valid = 1'b1;
        byte_data  = r_word[15:8];
        if (w_xfer) w_next = S_ACK;
      end
      S_ACK: begin
        req_ack = NUM_REQ'(1) << r_grant_id;
        w_next  = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        busy = 1'b0;
        if (r_gap_cnt == '0) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= IDW'(NUM_REQ - 1);
      r_gap_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_found) begin
        r_grant_id <= w_gidx;
        r_rr_ptr   <= w_gidx;
      end
      if (r_state == S_ACK)
        r_gap_cnt <= (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
      else if (r_state == S_GAP && r_gap_cnt != '0)
        r_gap_cnt <= r_gap_cnt - 1'b1;
    end
  end

  // The word is only observed through byte_data while a frame is active, so it needs no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_found)
      r_word <= req_data[int'(w_gidx)*16 +: 16];
  end

endmodule
